// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing one 7-seg decoder.
// Optional leading-zero blanking at commit when DISPLAY_SCAN_LZB_EN is defined.
module display_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic                      ready,
    output logic [3:0]                digit_code,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_done
);

    localparam int unsigned CntMax = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

    localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);
    localparam logic [CntW-1:0] ScanLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {StGuard, StScan} state_e;

    state_e                    state_q;
    logic [CntW-1:0]           cnt_q;
    logic [IdxW-1:0]           idx_q;
    logic [4*NUM_DIGITS-1:0]   act_val_q;
    logic [NUM_DIGITS-1:0]     act_mask_q;
    logic [4*NUM_DIGITS-1:0]   sh_val_q;
    logic [NUM_DIGITS-1:0]     sh_mask_q;
    logic                      pending_q;

    logic                      commit;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [NUM_DIGITS-1:0]     new_mask;
    logic [NUM_DIGITS-1:0]     scan_en;
    logic [IdxW-1:0]           idx_nxt;

    // Commit lands on the last guard cycle ahead of digit 0, i.e. at the frame boundary.
    assign commit = (state_q == StGuard) && (cnt_q == GuardLast) && (idx_q == '0) && pending_q;

`ifdef DISPLAY_SCAN_LZB_EN
    logic seen;
    always_comb begin
        lz_mask = '0;
        seen    = 1'b0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            seen       = seen | (sh_val_q[4*k +: 4] != 4'h0);
            lz_mask[k] = ~seen;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign new_mask = commit ? (sh_mask_q | lz_mask) : act_mask_q;
    assign idx_nxt  = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);

    always_comb begin
        scan_en = '1;
        if (!new_mask[idx_q]) begin
            scan_en[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StGuard;
            cnt_q      <= '0;
            idx_q      <= '0;
            act_val_q  <= '0;
            act_mask_q <= '0;
            sh_val_q   <= '0;
            sh_mask_q  <= '0;
            pending_q  <= 1'b0;
            ready      <= 1'b1;
            digit_code <= 4'h0;
            digit_en   <= '1;
            frame_done <= 1'b0;
        end else begin
            if (load && ready) begin
                sh_val_q  <= value;
                sh_mask_q <= blank_mask;
                pending_q <= 1'b1;
                ready     <= 1'b0;
            end else if (commit) begin
                pending_q <= 1'b0;
                ready     <= 1'b1;
            end

            if (commit) begin
                act_val_q  <= sh_val_q;
                act_mask_q <= sh_mask_q | lz_mask;
            end

            frame_done <= 1'b0;

            case (state_q)
                StGuard: begin
                    if (cnt_q == GuardLast) begin
                        state_q  <= StScan;
                        cnt_q    <= '0;
                        digit_en <= scan_en;
                        if (commit) begin
                            digit_code <= sh_val_q[3:0];
                        end
                        // A one-cycle slot makes the first scan cycle also the last.
                        if (REFRESH_DIV == 1 && idx_q == IdxLast) begin
                            frame_done <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StScan: begin
                    if (cnt_q == ScanLast) begin
                        state_q    <= StGuard;
                        cnt_q      <= '0;
                        idx_q      <= idx_nxt;
                        digit_en   <= '1;
                        digit_code <= act_val_q[idx_nxt*4 +: 4];
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (idx_q == IdxLast && (cnt_q + CntW'(1)) == ScanLast) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state_q <= StGuard;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-position reference model.
// Honours DISPLAY_SCAN_LZB_EN the same way as the design.
module tb_display_scan_ctrl;

    localparam int N      = 4;
    localparam int R      = 4;
    localparam int G      = 2;
    localparam int SLOT   = R + G;
    localparam int FRAME  = N * SLOT;
    localparam int CYCLES = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    blank_mask;
    logic          ready;
    logic [3:0]    digit_code;
    logic [3:0]    digit_en;
    logic          frame_done;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GUARD_CYCLES(G)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .blank_mask(blank_mask),
        .ready     (ready),
        .digit_code(digit_code),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference state: what is on screen, what is waiting, and time since reset.
    logic [15:0] m_val, m_sh_val;
    logic [3:0]  m_mask, m_sh_mask;
    bit          m_pend;
    int          t;

    function automatic logic [3:0] lzb(input logic [15:0] v);
        logic [3:0] m = 4'b0000;
`ifdef DISPLAY_SCAN_LZB_EN
        int hi = 0;
        for (int k = 0; k < N; k++) begin
            if (v[4*k +: 4] != 4'h0) hi = k;
        end
        for (int k = 0; k < N; k++) begin
            if (k > hi) m[k] = 1'b1;
        end
`endif
        return m;
    endfunction

    task automatic model_reset();
        m_val = '0; m_sh_val = '0; m_mask = '0; m_sh_mask = '0; m_pend = 0; t = 0;
    endtask

    task automatic model_step(input logic rst, input logic ld, input logic [15:0] v,
                              input logic [3:0] bm);
        int p;
        if (rst) begin
            model_reset();
        end else begin
            p = t % FRAME;
            if (ld && !m_pend) begin
                m_sh_val  = v;
                m_sh_mask = bm;
                m_pend    = 1;
            end else if (m_pend && p == G - 1) begin
                m_val  = m_sh_val;
                m_mask = m_sh_mask | lzb(m_sh_val);
                m_pend = 0;
            end
            t++;
        end
    endtask

    task automatic check_outputs();
        int p, d, ph;
        logic [3:0] exp_en;
        p  = t % FRAME;
        d  = p / SLOT;
        ph = p % SLOT;
        exp_en = 4'b1111;
        if (ph >= G && !m_mask[d]) exp_en[d] = 1'b0;
        check("digit_en",   32'(digit_en),   32'(exp_en));
        check("digit_code", 32'(digit_code), 32'(m_val[4*d +: 4]));
        check("ready",      32'(ready),      32'(!m_pend));
        check("frame_done", 32'(frame_done), 32'(p == FRAME - 1));
    endtask

    logic [15:0] vals [6] = '{16'h1A3F, 16'h5555, 16'h1234, 16'h0070, 16'h0000, 16'h0F00};

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        value      = '0;
        blank_mask = '0;
        repeat (2) @(posedge clk);
        model_reset();
        for (int c = 0; c < CYCLES; c++) begin
            @(negedge clk);
            check_outputs();
            reset = (c > 50) && ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 3) == 0);
            value = ($urandom_range(0, 1) == 0) ? vals[$urandom_range(0, 5)] : 16'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            model_step(reset, load, value, blank_mask);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
